// File: rtl/banked_scoreboard_register_file_if.sv
// Register-file access bundle: decode reads/reserves and writeback writes.
// master = datapath side driving requests, slave = register file answering them.
interface banked_scoreboard_register_file_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 6
);
  logic [ADDR_W-1:0] read_a;
  logic [ADDR_W-1:0] read_b;
  logic [WIDTH-1:0]  out_a;
  logic [WIDTH-1:0]  out_b;
  logic              busy_a;
  logic              busy_b;
  logic              write_enable;
  logic [ADDR_W-1:0] write_select;
  logic [WIDTH-1:0]  write_in;
  logic              reserve_enable;
  logic [ADDR_W-1:0] reserve_select;
  logic              reserve_conflict;
  logic [CNT_W-1:0]  pending_count;

  modport master (
    output read_a, read_b, write_enable, write_select, write_in,
           reserve_enable, reserve_select,
    input  out_a, out_b, busy_a, busy_b, reserve_conflict, pending_count
  );

  modport slave (
    input  read_a, read_b, write_enable, write_select, write_in,
           reserve_enable, reserve_select,
    output out_a, out_b, busy_a, busy_b, reserve_conflict, pending_count
  );
endinterface

// File: rtl/banked_scoreboard_register_file.sv
// Register file with write bypass, pending-write scoreboard and pending count; ZERO_REG_EN hardwires r0.
// Reads zero-cycle, state one cycle; reserve_conflict tells decode to stall and retry.
module banked_scoreboard_register_file #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 6
) (
  input logic clk,
  input logic reset,
  banked_scoreboard_register_file_if.slave rf
);

`ifdef ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] sb_q, sb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] raw_a, raw_b;
  logic             sb_a, sb_b, wr_pend, rsv_pend;
  logic             wr_ok, rsv_ok, wr_same, rsv_set, wr_clr;
  logic             byp_a, byp_b;

  // A select is live when it names a real register that can hold state.
  function automatic logic live(input logic [ADDR_W-1:0] sel);
    return ({1'b0, sel} < DEPTH_W) && !(ZERO_REG && (sel == '0));
  endfunction

  always_comb begin
    raw_a    = '0;
    raw_b    = '0;
    sb_a     = 1'b0;
    sb_b     = 1'b0;
    wr_pend  = 1'b0;
    rsv_pend = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rf.read_a == ADDR_W'(i)) begin
        raw_a = regs_q[i];
        sb_a  = sb_q[i];
      end
      if (rf.read_b == ADDR_W'(i)) begin
        raw_b = regs_q[i];
        sb_b  = sb_q[i];
      end
      if (rf.write_select == ADDR_W'(i))   wr_pend  = sb_q[i];
      if (rf.reserve_select == ADDR_W'(i)) rsv_pend = sb_q[i];
    end

    wr_ok   = rf.write_enable && live(rf.write_select);
    rsv_ok  = rf.reserve_enable && live(rf.reserve_select);
    wr_same = wr_ok && (rf.write_select == rf.reserve_select);
    // The write clears the bit before the reserve looks at it.
    rsv_set = rsv_ok && (!rsv_pend || wr_same);
    wr_clr  = wr_ok && wr_pend;

    byp_a = wr_ok && (rf.write_select == rf.read_a);
    byp_b = wr_ok && (rf.write_select == rf.read_b);

    rf.out_a  = !live(rf.read_a) ? '0 : (byp_a ? rf.write_in : raw_a);
    rf.out_b  = !live(rf.read_b) ? '0 : (byp_b ? rf.write_in : raw_b);
    rf.busy_a = live(rf.read_a) && !byp_a && sb_a;
    rf.busy_b = live(rf.read_b) && !byp_b && sb_b;
    rf.reserve_conflict = rsv_ok && rsv_pend && !wr_same;
    rf.pending_count    = cnt_q;
  end

  always_comb begin
    regs_d = regs_q;
    sb_d   = sb_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_ok && (rf.write_select == ADDR_W'(i))) begin
        regs_d[i] = rf.write_in;
        sb_d[i]   = 1'b0;
      end
      if (rsv_set && (rf.reserve_select == ADDR_W'(i))) sb_d[i] = 1'b1;
    end
    cnt_d = cnt_q + CNT_W'(rsv_set) - CNT_W'(wr_clr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      sb_q  <= '0;
      cnt_q <= '0;
    end else begin
      regs_q <= regs_d;
      sb_q   <= sb_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_banked_scoreboard_register_file.sv
// Bench: directed plan steps then random traffic, against a 32-deep and a 20-deep instance.
// Reference model keeps per-register value/pending arrays; the count is a popcount of pending bits.
module tb_banked_scoreboard_register_file;

`ifdef ZERO_REG_EN
  localparam bit Z = 1'b1;
`else
  localparam bit Z = 1'b0;
`endif

  logic clk;
  logic reset;
  int   total;
  int   bad;

  banked_scoreboard_register_file_if #(.WIDTH(32), .ADDR_W(5), .CNT_W(6)) if0 ();
  banked_scoreboard_register_file_if #(.WIDTH(32), .ADDR_W(5), .CNT_W(6)) if1 ();

  assign if1.read_a         = if0.read_a;
  assign if1.read_b         = if0.read_b;
  assign if1.write_enable   = if0.write_enable;
  assign if1.write_select   = if0.write_select;
  assign if1.write_in       = if0.write_in;
  assign if1.reserve_enable = if0.reserve_enable;
  assign if1.reserve_select = if0.reserve_select;

  banked_scoreboard_register_file #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .CNT_W(6)) dut0 (
    .clk(clk), .reset(reset), .rf(if0.slave)
  );
  banked_scoreboard_register_file #(.WIDTH(32), .DEPTH(20), .ADDR_W(5), .CNT_W(6)) dut1 (
    .clk(clk), .reset(reset), .rf(if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem  [2][32];
  bit          pend [2][32];

  function automatic int dep(input int d);
    return (d == 0) ? 32 : 20;
  endfunction

  function automatic bit live_m(input int d, input int s);
    return (s < dep(d)) && !(Z && s == 0);
  endfunction

  function automatic logic [31:0] e_out(input int d, input int s);
    if (!live_m(d, s)) return 32'h0;
    if (if0.write_enable && int'(if0.write_select) == s) return if0.write_in;
    return mem[d][s];
  endfunction

  function automatic logic e_busy(input int d, input int s);
    if (!live_m(d, s)) return 1'b0;
    if (if0.write_enable && int'(if0.write_select) == s) return 1'b0;
    return pend[d][s];
  endfunction

  function automatic logic e_conf(input int d);
    int rs;
    rs = int'(if0.reserve_select);
    return if0.reserve_enable && live_m(d, rs) && pend[d][rs] &&
           !(if0.write_enable && int'(if0.write_select) == rs);
  endfunction

  function automatic int e_cnt(input int d);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) n += int'(pend[d][i]);
    return n;
  endfunction

  task automatic upd(input int d);
    int ws, rs;
    ws = int'(if0.write_select);
    rs = int'(if0.reserve_select);
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        mem[d][i]  = 32'h0;
        pend[d][i] = 1'b0;
      end
    end else begin
      if (if0.write_enable && live_m(d, ws)) begin
        mem[d][ws]  = if0.write_in;
        pend[d][ws] = 1'b0;
      end
      if (if0.reserve_enable && live_m(d, rs) && !pend[d][rs]) pend[d][rs] = 1'b1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("d0_out_a",  64'(if0.out_a),  64'(e_out(0, int'(if0.read_a))));
    check("d0_out_b",  64'(if0.out_b),  64'(e_out(0, int'(if0.read_b))));
    check("d0_busy_a", 64'(if0.busy_a), 64'(e_busy(0, int'(if0.read_a))));
    check("d0_busy_b", 64'(if0.busy_b), 64'(e_busy(0, int'(if0.read_b))));
    check("d0_conf",   64'(if0.reserve_conflict), 64'(e_conf(0)));
    check("d0_cnt",    64'(if0.pending_count),    64'(e_cnt(0)));
    check("d1_out_a",  64'(if1.out_a),  64'(e_out(1, int'(if0.read_a))));
    check("d1_out_b",  64'(if1.out_b),  64'(e_out(1, int'(if0.read_b))));
    check("d1_busy_a", 64'(if1.busy_a), 64'(e_busy(1, int'(if0.read_a))));
    check("d1_busy_b", 64'(if1.busy_b), 64'(e_busy(1, int'(if0.read_b))));
    check("d1_conf",   64'(if1.reserve_conflict), 64'(e_conf(1)));
    check("d1_cnt",    64'(if1.pending_count),    64'(e_cnt(1)));
  endtask

  task automatic drv(input logic [4:0] ra, input logic [4:0] rb, input logic we,
                     input logic [4:0] ws, input logic [31:0] wi, input logic re,
                     input logic [4:0] rs);
    if0.read_a         = ra;
    if0.read_b         = rb;
    if0.write_enable   = we;
    if0.write_select   = ws;
    if0.write_in       = wi;
    if0.reserve_enable = re;
    if0.reserve_select = rs;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
    check_all();
  endtask

  task automatic tick();
    @(posedge clk);
    upd(0);
    upd(1);
    #1;
  endtask

  initial begin
    logic [4:0] ws, rs, ra, rb;
    total = 0;
    bad   = 0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 32; i++) begin
        mem[d][i]  = 32'h0;
        pend[d][i] = 1'b0;
      end
    reset = 1'b1;
    drv(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    tick();
    tick();
    reset = 1'b0;

    drv(5'd3, 5'd31, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    settle();
    check("tp_rst_out_a", 64'(if0.out_a), 64'h0);
    check("tp_rst_out_b", 64'(if0.out_b), 64'h0);
    check("tp_rst_cnt", 64'(if0.pending_count), 64'h0);
    tick();

    drv(5'd5, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0);
    settle();
    check("tp_bypass", 64'(if0.out_a), 64'hDEADBEEF);
    tick();
    drv(5'd5, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    settle();
    check("tp_held", 64'(if0.out_a), 64'hDEADBEEF);
    tick();

    drv(5'd7, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
    settle(); tick();
    drv(5'd7, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
    settle();
    check("tp_busy7", 64'(if0.busy_a), 64'h1);
    check("tp_cnt1", 64'(if0.pending_count), 64'h1);
    check("tp_conf7", 64'(if0.reserve_conflict), 64'h1);
    tick();
    drv(5'd7, 5'd0, 1'b1, 5'd7, 32'h12, 1'b0, 5'd0);
    settle();
    check("tp_cnt_hold", 64'(if0.pending_count), 64'h1);
    check("tp_wr_busy", 64'(if0.busy_a), 64'h0);
    tick();
    drv(5'd7, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    settle();
    check("tp_cnt0", 64'(if0.pending_count), 64'h0);
    tick();

    drv(5'd9, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
    settle(); tick();
    drv(5'd9, 5'd9, 1'b1, 5'd9, 32'h55, 1'b1, 5'd9);
    settle();
    check("tp_wr_rsv_conf", 64'(if0.reserve_conflict), 64'h0);
    check("tp_wr_rsv_out", 64'(if0.out_a), 64'h55);
    tick();
    drv(5'd9, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    settle();
    check("tp_wr_rsv_busy", 64'(if0.busy_a), 64'h1);
    check("tp_wr_rsv_cnt", 64'(if0.pending_count), 64'h1);
    tick();

    for (int i = 1; i < 32; i++) begin
      drv(5'(i), 5'(i - 1), 1'b0, 5'd0, 32'h0, 1'b1, 5'(i));
      settle(); tick();
    end
    drv(5'd31, 5'd1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    settle();
    check("tp_cnt31", 64'(if0.pending_count), 64'd31);
    tick();
    reset = 1'b1;
    drv(5'd4, 5'd9, 1'b1, 5'd4, 32'hAA, 1'b1, 5'd2);
    settle(); tick();
    reset = 1'b0;
    drv(5'd4, 5'd9, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    settle();
    check("tp_rst_cnt0", 64'(if0.pending_count), 64'h0);
    check("tp_rst_busy", 64'(if0.busy_b), 64'h0);
    check("tp_rst_wr", 64'(if0.out_a), 64'h0);
    tick();

    drv(5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0);
    settle(); tick();
    drv(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    settle();
    check("tp_r0_out", 64'(if0.out_a), Z ? 64'h0 : 64'hFFFFFFFF);
    check("tp_r0_cnt", 64'(if0.pending_count), Z ? 64'h0 : 64'h1);
    tick();

    for (int n = 0; n < 600; n++) begin
      ws = 5'($urandom_range(0, 31));
      rs = ($urandom_range(0, 3) == 0) ? ws : 5'($urandom_range(0, 31));
      ra = ($urandom_range(0, 3) == 0) ? ws : 5'($urandom_range(0, 31));
      rb = ($urandom_range(0, 3) == 0) ? rs : 5'($urandom_range(0, 31));
      reset = ($urandom_range(0, 79) == 0);
      drv(ra, rb, 1'($urandom_range(0, 2) == 0), ws, $urandom(),
          1'($urandom_range(0, 1)), rs);
      settle(); tick();
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
